// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and event bit ordering for button event logic
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } btn_state_t;

    // Event vector bit positions, shared with the register block
    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;
    localparam int EV_REPEAT  = 3;
    localparam int EV_W       = 4;

endpackage

// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - debounced button level to press/release/long-press/repeat pulses
module button_event_gen
    import btn_pkg::*;
#(
    parameter bit ACTIVE_HIGH   = 1'b1,
    parameter int LONG_CYCLES   = 4096,
    parameter int REPEAT_CYCLES = 1024,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clean,
    output logic       press,
    output logic       release_pulse,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    if (LONG_CYCLES < 1 || LONG_CYCLES >= (1 << CNT_W) || REPEAT_CYCLES >= (1 << CNT_W)) begin : g_bad_params
        $error("button_event_gen: LONG_CYCLES/REPEAT_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam bit               REP_EN    = (REPEAT_CYCLES != 0);

    logic             s_q;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [EV_W-1:0]  ev_q, ev_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             held_q;

    // Release is checked first in every held state so it wins over long/repeat
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        ev_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (s_q) begin
                    state_d        = ST_PRESSED;
                    ev_d[EV_PRESS] = 1'b1;
                    hold_d         = '0;
                    cnt_d          = cnt_q + 8'd1;
                end
            end
            ST_PRESSED: begin
                if (!s_q) begin
                    state_d          = ST_IDLE;
                    ev_d[EV_RELEASE] = 1'b1;
                end else if (hold_q == LONG_LAST) begin
                    state_d       = ST_LONG;
                    ev_d[EV_LONG] = 1'b1;
                    rep_d         = '0;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            ST_LONG: begin
                if (!s_q) begin
                    state_d          = ST_IDLE;
                    ev_d[EV_RELEASE] = 1'b1;
                end else if (REP_EN) begin
                    if (rep_q == REP_LAST) begin
                        ev_d[EV_REPEAT] = 1'b1;
                        rep_d           = '0;
                    end else begin
                        rep_d = rep_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= 1'b0;
            state_q <= ST_IDLE;
            hold_q  <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            ev_q    <= '0;
            held_q  <= 1'b0;
        end else begin
            s_q     <= (clean ~^ ACTIVE_HIGH);
            state_q <= state_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            ev_q    <= ev_d;
            held_q  <= (state_d != ST_IDLE);
        end
    end

    assign press         = ev_q[EV_PRESS];
    assign release_pulse = ev_q[EV_RELEASE];
    assign long_press    = ev_q[EV_LONG];
    assign repeat_pulse  = ev_q[EV_REPEAT];
    assign held          = held_q;
    assign press_count   = cnt_q;

endmodule

// File: tb/tb_button_event_gen.sv
// tb/tb_button_event_gen.sv - self-checking bench for button_event_gen, both polarities
module tb_button_event_gen;

    localparam int L = 8;
    localparam int R = 4;
    localparam int W = 4;

    localparam logic [3:0] C_PRESS = 4'b0001;
    localparam logic [3:0] C_REL   = 4'b0010;
    localparam logic [3:0] C_LONG  = 4'b0100;
    localparam logic [3:0] C_REP   = 4'b1000;

    typedef struct {
        int          cyc;
        logic [3:0]  code;
    } exp_t;

    typedef struct {
        int hold;
        int exp_long;
        int exp_rep;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic clean_drv;
    logic clean_n;
    assign clean_n = ~clean_drv;

    logic       pr0, rl0, lp0, rp0, hd0;
    logic       pr1, rl1, lp1, rp1, hd1;
    logic [7:0] pc0, pc1;

    button_event_gen #(.ACTIVE_HIGH(1'b1), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(W)) dut0 (
        .clk(clk), .rst(rst), .clean(clean_drv),
        .press(pr0), .release_pulse(rl0), .long_press(lp0), .repeat_pulse(rp0),
        .held(hd0), .press_count(pc0)
    );

    button_event_gen #(.ACTIVE_HIGH(1'b0), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(W)) dut1 (
        .clk(clk), .rst(rst), .clean(clean_n),
        .press(pr1), .release_pulse(rl1), .long_press(lp1), .repeat_pulse(rp1),
        .held(hd1), .press_count(pc1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] evv [2];
    logic       hv  [2];
    logic [7:0] pcv [2];
    assign evv[0] = {rp0, lp0, rl0, pr0};
    assign evv[1] = {rp1, lp1, rl1, pr1};
    assign hv[0]  = hd0;
    assign hv[1]  = hd1;
    assign pcv[0] = pc0;
    assign pcv[1] = pc1;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq [2][$];
    logic exp_held [2];
    int   n_long [2];
    int   n_rep  [2];
    int   exp_cnt;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] code);
        exp_t e;
        e.cyc  = c;
        e.code = code;
        sbq[0].push_back(e);
        sbq[1].push_back(e);
    endtask

    // Scoreboard monitor: pops expected pulses by cycle and tracks the expected held level
    exp_t       mon_e;
    logic [3:0] mon_ev;
    initial begin
        exp_held = '{1'b0, 1'b0};
        n_long   = '{0, 0};
        n_rep    = '{0, 0};
    end
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mon_ev = evv[i];
            if (rst) begin
                chk($sformatf("rst_quiet%0d", i), {hv[i], mon_ev}, 0);
                exp_held[i] = 1'b0;
            end else begin
                while (sbq[i].size() > 0 && sbq[i][0].cyc < cyc) begin
                    chk($sformatf("missed_evt%0d_c%0d", i, sbq[i][0].cyc), 0, sbq[i][0].code);
                    void'(sbq[i].pop_front());
                end
                if (sbq[i].size() > 0 && sbq[i][0].cyc == cyc) begin
                    mon_e = sbq[i].pop_front();
                    chk($sformatf("event%0d", i), mon_ev, mon_e.code);
                    if (mon_e.code == C_PRESS) exp_held[i] = 1'b1;
                    if (mon_e.code == C_REL)   exp_held[i] = 1'b0;
                end else if (mon_ev != 4'b0000) begin
                    chk($sformatf("unexpected_evt%0d", i), mon_ev, 0);
                end
                if (mon_ev == C_LONG) n_long[i] = n_long[i] + 1;
                if (mon_ev == C_REP)  n_rep[i]  = n_rep[i] + 1;
                chk($sformatf("held%0d", i), hv[i], exp_held[i]);
            end
        end
    end

    // Drive one press: clean active for h sampled edges, then inactive for gap edges
    task automatic press_seg(input int h, input int gap);
        int e0;
        @(negedge clk);
        e0 = cyc + 1;
        clean_drv = 1'b1;
        push(e0 + 1, C_PRESS);
        exp_cnt = (exp_cnt + 1) % 256;
        if (h >= L + 1) begin
            push(e0 + 1 + L, C_LONG);
            for (int t = e0 + 1 + L + R; t <= e0 + h; t += R) push(t, C_REP);
        end
        push(e0 + h + 1, C_REL);
        repeat (h) @(negedge clk);
        clean_drv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    vec_t tbl [7];
    int   base_l [2];
    int   base_r [2];
    int   c0;
    int   nwrap;

    initial begin
        tbl[0] = '{hold: 1,  exp_long: 0, exp_rep: 0};
        tbl[1] = '{hold: 5,  exp_long: 0, exp_rep: 0};
        tbl[2] = '{hold: 8,  exp_long: 0, exp_rep: 0};
        tbl[3] = '{hold: 9,  exp_long: 1, exp_rep: 0};
        tbl[4] = '{hold: 12, exp_long: 1, exp_rep: 0};
        tbl[5] = '{hold: 13, exp_long: 1, exp_rep: 1};
        tbl[6] = '{hold: 30, exp_long: 1, exp_rep: 5};

        rst       = 1'b1;
        clean_drv = 1'bx;
        exp_cnt   = 0;
        repeat (3) @(negedge clk);
        chk("reset_cnt0", pc0, 0);
        chk("reset_cnt1", pc1, 0);
        chk("reset_out0", {hd0, rp0, lp0, rl0, pr0}, 0);
        chk("reset_out1", {hd1, rp1, lp1, rl1, pr1}, 0);
        clean_drv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_cnt0", pc0, 0);
        chk("idle_cnt1", pc1, 0);

        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 2; i++) begin
                base_l[i] = n_long[i];
                base_r[i] = n_rep[i];
            end
            press_seg(tbl[k].hold, 4);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("row%0d_long%0d", k, i), n_long[i] - base_l[i], tbl[k].exp_long);
                chk($sformatf("row%0d_rep%0d", k, i), n_rep[i] - base_r[i], tbl[k].exp_rep);
                chk($sformatf("row%0d_cnt%0d", k, i), pcv[i], exp_cnt);
            end
        end
        chk("table_cnt_total", pc0, 7);

        // Reset while in LONG with the button still held
        @(negedge clk);
        c0 = cyc;
        clean_drv = 1'b1;
        push(c0 + 2, C_PRESS);
        push(c0 + 2 + L, C_LONG);
        exp_cnt = (exp_cnt + 1) % 256;
        repeat (L + 3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out0", {hd0, rp0, lp0, rl0, pr0}, 0);
        chk("async_rst_out1", {hd1, rp1, lp1, rl1, pr1}, 0);
        chk("async_rst_cnt0", pc0, 0);
        chk("async_rst_cnt1", pc1, 0);
        exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push(cyc + 2, C_PRESS);
        exp_cnt = 1;
        repeat (4) @(negedge clk);
        clean_drv = 1'b0;
        push(cyc + 2, C_REL);
        repeat (4) @(negedge clk);
        chk("post_rst_cnt0", pc0, 1);
        chk("post_rst_cnt1", pc1, 1);

        // press_count wrap 255 -> 0, then 1
        nwrap = 256 - exp_cnt;
        for (int k = 0; k < nwrap; k++) press_seg(1, 2);
        chk("wrap_cnt0", pc0, 0);
        chk("wrap_cnt1", pc1, 0);
        press_seg(1, 2);
        chk("wrap_next0", pc0, 1);
        chk("wrap_next1", pc1, 1);

        repeat (5) @(negedge clk);
        chk("sb_empty", sbq[0].size() + sbq[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
